serial_addsub: RTL
==================

# serial_addsub

Parametrised digit-serial adder/subtractor with a start/done handshake. It latches two WIDTH-bit operands and processes DIGIT bits per cycle from the LSB upward. It produces the sum or difference plus carry-out and signed overflow flags. It is the general-purpose successor to the fixed 8-bit, 1-bit-per-cycle serial adder, and sits in datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT == 0 is required (elaboration error otherwise).
- N (localparam), WIDTH/DIGIT, number of compute cycles.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- sub  input  1  0 computes a+b, 1 computes a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in ADD and DONE.
- done  output  1  one-cycle pulse; result valid.
- out  output  WIDTH  result, held from done until the next accepted start.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Reset (async, rst=1): state=IDLE; out, cout, ovf, busy, done, count, carry, a_reg and b_reg are all 0.
- FSM states: IDLE, ADD, DONE. The state register is 2 bits; the unused encoding returns to IDLE.
- IDLE + start=1: set a_reg=a, b_reg = sub ? ~b : b, carry=sub, count=0, go to ADD. With start=0, stay in IDLE and hold all outputs.
- ADD, each cycle:
  - Digit sum: {c, s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, computed at DIGIT+1 bits.
  - out <= {s, out[WIDTH-1:DIGIT]}.
  - a_reg and b_reg shift right by DIGIT.
  - carry <= c.
  - count increments.
- ADD, final digit (count==N-1):
  - cout <= c.
  - ovf <= carry into the MSB XOR carry out of the MSB. This needs the bit-level carry into bit WIDTH-1 inside the last digit.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- start is ignored in ADD and DONE. Operands must be re-presented after returning to IDLE.
- During ADD, out holds partial, shifted data and must not be used. out, cout and ovf are final when done=1 and stay stable until the cycle after the next accepted start.
- Arithmetic is modulo 2^WIDTH. For subtract, out = a + ~b + 1.
- Reset asserted mid-operation aborts immediately to IDLE with all registers cleared. No done pulse is produced.
- count is $clog2(N) bits; for N=1 it is a 1-bit register. The FSM still spends exactly one ADD cycle.

## Timing
- start is sampled at edge 0. ADD occupies edges 1..N, and done/busy are observed high in the cycle after edge N.
- Latency from start acceptance to done: N+1 cycles.
- Throughput: one operation per N+2 cycles. The earliest re-accept is the cycle after done.
- busy rises the cycle after the accepting edge and falls together with done.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_SAT_EN defined: when ovf is set, out is clamped. For positive overflow, out = {1'b0, {WIDTH-1{1'b1}}}. For negative overflow, out = {1'b1, {WIDTH-1{1'b0}}}. The clamp is applied in the final ADD cycle, so latency is unchanged. ovf and cout still report the raw result.
- Not defined: out is the wrapped modulo result and no clamp logic is generated.

## Test plan
- WIDTH=8, DIGIT=1: a=0x35, b=0x4A, sub=0 → done 9 cycles after start, out=0x7F, cout=0, ovf=0, busy high for 9 cycles.
- WIDTH=8: 0xFF+0x01 → out=0x00, cout=1, ovf=0. 0x7F+0x01 → out=0x80 (0x7F with SAT_EN), ovf=1.
- WIDTH=8, sub=1: 0x10−0x20 → out=0xF0, cout=0, ovf=0. 0x80−0x01 → out=0x7F (0x80 with SAT_EN), ovf=1, cout=1.
- WIDTH=16, DIGIT=4: 0x1234+0x0FCD → out=0x2201, done 5 cycles after start. A start pulse with other operands while busy is ignored and the result is unchanged.
- rst pulsed at ADD cycle 3 → outputs immediately 0, no done pulse. A new start after reset gives the correct result with no residual carry.
- Back-to-back: start held high continuously → operations accepted every N+2 cycles, and out holds each result until the next acceptance.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master side issues start/sub/a/b; the slave side returns the registered result and status.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, out, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, with start/done handshake.
// Optional macro SERIAL_ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = DIGIT + 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_addsub: WIDTH must be at least 2");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [WIDTH-1:0] b_reg, b_nxt;
  logic             carry, carry_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] out_r, out_nxt;
  logic             cout_r, cout_nxt;
  logic             ovf_r, ovf_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;

  logic [DIGIT:0]   dsum_c;
  logic [DIGIT-1:0] dsum_s_c;
  logic             dcarry_c;
  logic             msb_cin_c;
  logic             ovf_c;
  logic             last_c;

  // Current digit sum; carry into the word MSB recovered from the top bit of the last digit
  assign dsum_c    = DW'(a_reg[DIGIT-1:0]) + DW'(b_reg[DIGIT-1:0]) + DW'(carry);
  assign dsum_s_c  = dsum_c[DIGIT-1:0];
  assign dcarry_c  = dsum_c[DIGIT];
  assign msb_cin_c = dsum_c[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
  assign ovf_c     = msb_cin_c ^ dcarry_c;
  assign last_c    = (count == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      count  <= '0;
      out_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      b_reg  <= b_nxt;
      carry  <= carry_nxt;
      count  <= count_nxt;
      out_r  <= out_nxt;
      cout_r <= cout_nxt;
      ovf_r  <= ovf_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    carry_nxt = carry;
    count_nxt = count;
    out_nxt   = out_r;
    cout_nxt  = cout_r;
    ovf_nxt   = ovf_r;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          // Subtract is a + ~b + 1: invert b and seed the carry
          a_nxt     = bus.a;
          b_nxt     = bus.sub ? ~bus.b : bus.b;
          carry_nxt = bus.sub;
          count_nxt = '0;
          busy_nxt  = 1'b1;
          state_nxt = ADD;
        end
      end

      ADD: begin
        busy_nxt  = 1'b1;
        out_nxt   = (out_r >> DIGIT) | (WIDTH'(dsum_s_c) << (WIDTH - DIGIT));
        a_nxt     = a_reg >> DIGIT;
        b_nxt     = b_reg >> DIGIT;
        carry_nxt = dcarry_c;
        count_nxt = count + CW'(1);
        if (last_c) begin
          cout_nxt  = dcarry_c;
          ovf_nxt   = ovf_c;
          done_nxt  = 1'b1;
          state_nxt = DONE;
`ifdef SERIAL_ADDSUB_SAT_EN
          // On overflow both operand signs agree, so the carry-out gives the true sign
          if (ovf_c) begin
            out_nxt = dcarry_c ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.out  = out_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
